// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer: FSM state encoding and
// width arithmetic used when sizing the slice counter.
package word_serializer_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } ser_state_t;

  // A counter that only ever holds 0 still needs one bit to exist.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dvr_if.sv
// Data/valid/ready handshake bundle. The master modport is the sink side
// (drives rdy); the slave modport is the source side (drives vld and data).
interface dvr_if #(
  parameter int WIDTH = 8
);
  logic             vld;
  logic             rdy;
  logic [WIDTH-1:0] data;

  modport master (input vld, input data, output rdy);
  modport slave  (output vld, output data, input rdy);
endinterface

// File: rtl/word_serializer.sv
// Registered width downsizer: takes one IN_WIDTH word and emits it as RATIO
// OUT_WIDTH slices, least-significant slice first, with no bubble between words.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int OUT_WIDTH = 8,
  parameter int RATIO     = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  dvr_if.master  in,
  dvr_if.slave   out,
  output logic   out_last,
  output logic   busy
);

  localparam int IN_WIDTH  = OUT_WIDTH * RATIO;
  localparam int IDX_WIDTH = clog2_min1(RATIO);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);

  generate
    if (OUT_WIDTH < 1 || RATIO < 1) begin : g_bad_params
      $error("word_serializer: OUT_WIDTH and RATIO must both be >= 1");
    end
  endgenerate

  ser_state_t            state_reg, state_next;
  logic [IDX_WIDTH-1:0]  idx_reg,   idx_next;
  logic [IN_WIDTH-1:0]   hold_reg,  hold_next;

  logic loaded;
  logic at_last;
  logic take;
  logic in_fire;
  logic out_fire;

  assign loaded   = (state_reg == ST_HOLD);
  assign at_last  = (idx_reg == LAST_IDX);
  // Refill is allowed in the same cycle the final slice leaves, so ready
  // depends combinationally on the downstream ready.
  assign take     = ~loaded | (out.rdy & at_last);
  assign in_fire  = in.vld & take;
  assign out_fire = loaded & out.rdy;

  assign in.rdy   = take;
  assign out.vld  = loaded;
  assign out.data = hold_reg[idx_reg * OUT_WIDTH +: OUT_WIDTH];
  assign out_last = loaded & at_last;
  assign busy     = loaded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      idx_reg   <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    hold_next  = hold_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (in_fire) begin
          hold_next  = in.data;
          idx_next   = '0;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_fire) begin
          if (!at_last) begin
            idx_next = idx_reg + IDX_WIDTH'(1);
          end else if (in_fire) begin
            hold_next = in.data;
            idx_next  = '0;
          end else begin
            idx_next   = '0;
            state_next = ST_EMPTY;
          end
        end
      end
      default: begin
        state_next = ST_EMPTY;
        idx_next   = '0;
      end
    endcase
  end

endmodule
